prco_mem_ctrl: RTL and testbench

Memory access controller that initiates all traffic to the core's local on-chip memory. It arbitrates between the instruction-fetch stage and the load/store path, then drives the memory's fetch/ALU chip-enable strobes, address, write enable and write data. It waits for the memory's decode/register completion strobe, captures the returned word, and hands it back to the requester with a one-cycle acknowledge. It sits between the pipeline front end and the local memory, replacing direct strobe wiring.

---
 rtl/prco_mem_ctrl_pkg.sv | 19 +
 rtl/prco_mem_watchdog.sv | 28 ++
 rtl/prco_mem_ctrl.sv | 134 +++++++++++++
 tb/tb_prco_mem_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prco_mem_ctrl_pkg.sv
// rtl/prco_mem_ctrl_pkg.sv - shared state/owner encodings for prco_mem_ctrl
package prco_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  function automatic int unsigned wd_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/prco_mem_watchdog.sv
// rtl/prco_mem_watchdog.sv - WAIT-cycle counter; o_expire flags the last allowed WAIT cycle
module prco_mem_watchdog
  import prco_mem_ctrl_pkg::*;
#(
  parameter int P_TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire
);

  localparam int LP_W = wd_width(P_TIMEOUT);

  logic [LP_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_load) begin
      r_cnt <= '0;
    end else if (i_count && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_count && (r_cnt == LP_W'(P_TIMEOUT - 1));

endmodule

// File: rtl/prco_mem_ctrl.sv
// rtl/prco_mem_ctrl.sv - local memory access controller, load/store over fetch priority
// PRCO_MEM_TIMEOUT_EN builds the WAIT watchdog and sticky q_err.
module prco_mem_ctrl
  import prco_mem_ctrl_pkg::*;
#(
  parameter int P_ADDR_W  = 16,
  parameter int P_DATA_W  = 16,
  parameter int P_TIMEOUT = 15
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_fetch_req,
  input  logic [P_ADDR_W-1:0] i_fetch_addr,
  output logic                q_fetch_ack,
  output logic [P_DATA_W-1:0] q_fetch_instr,
  input  logic                i_ls_req,
  input  logic                i_ls_we,
  input  logic [P_ADDR_W-1:0] i_ls_addr,
  input  logic [P_DATA_W-1:0] i_ls_wdata,
  output logic                q_ls_ack,
  output logic [P_DATA_W-1:0] q_ls_rdata,
  output logic                q_mem_ce_fetch,
  output logic                q_mem_ce_alu,
  output logic                q_mem_we,
  output logic [P_ADDR_W-1:0] q_mem_addr,
  output logic [P_DATA_W-1:0] q_mem_dina,
  input  logic                i_mem_ce_dec,
  input  logic                i_mem_ce_reg,
  input  logic [P_DATA_W-1:0] i_mem_douta,
  output logic                q_busy,
  output logic                q_err
);

  if (P_TIMEOUT < 1) begin : g_bad_timeout
    $error("prco_mem_ctrl: P_TIMEOUT must be at least 1");
  end

  state_t              r_state, w_state_nxt;
  owner_t              r_owner;
  logic                w_accept, w_accept_ls, w_match, w_expire, w_done;
  logic [P_DATA_W-1:0] w_rdata;
  logic                r_ce_fetch, r_ce_alu, r_we, r_fetch_ack, r_ls_ack;
  logic [P_ADDR_W-1:0] r_addr;
  logic [P_DATA_W-1:0] r_dina, r_instr, r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_fetch_req || i_ls_req) w_state_nxt = ST_WAIT;
      ST_WAIT: if (w_done) w_state_nxt = ST_ACK;
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Only the owner's completion strobe counts; the other one is noise.
  always_comb begin
    w_accept    = (r_state == ST_IDLE) && (i_fetch_req || i_ls_req);
    w_accept_ls = w_accept && i_ls_req;
    w_match     = (r_state == ST_WAIT) &&
                  ((r_owner == OWN_FETCH) ? i_mem_ce_dec : i_mem_ce_reg);
    w_done      = w_match || w_expire;
    w_rdata     = w_match ? i_mem_douta : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_owner     <= OWN_FETCH;
      r_ce_fetch  <= 1'b0;
      r_ce_alu    <= 1'b0;
      r_we        <= 1'b0;
      r_fetch_ack <= 1'b0;
      r_ls_ack    <= 1'b0;
      r_addr      <= '0;
      r_dina      <= '0;
      r_instr     <= '0;
      r_rdata     <= '0;
    end else begin
      r_ce_fetch  <= w_accept && !i_ls_req;
      r_ce_alu    <= w_accept_ls;
      r_we        <= w_accept_ls && i_ls_we;
      r_fetch_ack <= w_done && (r_owner == OWN_FETCH);
      r_ls_ack    <= w_done && (r_owner == OWN_DATA);
      if (w_accept) begin
        r_owner <= i_ls_req ? OWN_DATA : OWN_FETCH;
        r_addr  <= i_ls_req ? i_ls_addr : i_fetch_addr;
        r_dina  <= i_ls_req ? i_ls_wdata : '0;
      end
      if (w_done && (r_owner == OWN_FETCH)) r_instr <= w_rdata;
      if (w_done && (r_owner == OWN_DATA))  r_rdata <= w_rdata;
    end
  end

`ifdef PRCO_MEM_TIMEOUT_EN
  logic r_err;

  prco_mem_watchdog #(
    .P_TIMEOUT (P_TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (w_accept),
    .i_count  (r_state == ST_WAIT),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset)                  r_err <= 1'b0;
    else if (w_expire && !w_match) r_err <= 1'b1;
  end

  assign q_err = r_err;
`else
  assign w_expire = 1'b0;
  assign q_err    = 1'b0;
`endif

  assign q_fetch_ack    = r_fetch_ack;
  assign q_fetch_instr  = r_instr;
  assign q_ls_ack       = r_ls_ack;
  assign q_ls_rdata     = r_rdata;
  assign q_mem_ce_fetch = r_ce_fetch;
  assign q_mem_ce_alu   = r_ce_alu;
  assign q_mem_we       = r_we;
  assign q_mem_addr     = r_addr;
  assign q_mem_dina     = r_dina;
  assign q_busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_prco_mem_ctrl.sv
// tb/tb_prco_mem_ctrl.sv - scoreboard bench for prco_mem_ctrl
// Watchdog scenario runs when PRCO_MEM_TIMEOUT_EN is defined.
module tb_prco_mem_ctrl;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_fetch_req, i_ls_req, i_ls_we;
  logic [AW-1:0] i_fetch_addr, i_ls_addr;
  logic [DW-1:0] i_ls_wdata;
  logic          q_fetch_ack, q_ls_ack, q_mem_ce_fetch, q_mem_ce_alu, q_mem_we;
  logic [DW-1:0] q_fetch_instr, q_ls_rdata, q_mem_dina;
  logic [AW-1:0] q_mem_addr;
  logic          ce_dec, ce_reg;
  logic [DW-1:0] douta;
  logic          q_busy, q_err;

  always #5 clk = ~clk;

  prco_mem_ctrl #(
    .P_ADDR_W (AW),
    .P_DATA_W (DW),
    .P_TIMEOUT(TO)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_fetch_req   (i_fetch_req),
    .i_fetch_addr  (i_fetch_addr),
    .q_fetch_ack   (q_fetch_ack),
    .q_fetch_instr (q_fetch_instr),
    .i_ls_req      (i_ls_req),
    .i_ls_we       (i_ls_we),
    .i_ls_addr     (i_ls_addr),
    .i_ls_wdata    (i_ls_wdata),
    .q_ls_ack      (q_ls_ack),
    .q_ls_rdata    (q_ls_rdata),
    .q_mem_ce_fetch(q_mem_ce_fetch),
    .q_mem_ce_alu  (q_mem_ce_alu),
    .q_mem_we      (q_mem_we),
    .q_mem_addr    (q_mem_addr),
    .q_mem_dina    (q_mem_dina),
    .i_mem_ce_dec  (ce_dec),
    .i_mem_ce_reg  (ce_reg),
    .i_mem_douta   (douta),
    .q_busy        (q_busy),
    .q_err         (q_err)
  );

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_fetch_q[$];
  logic [DW-1:0] exp_ls_q[$];
  int            fetch_strobe_cycs[$];
  logic          mem_silent;
  int            cyc;
  int            last_fetch_strobe_cyc, last_fetch_ack_cyc, last_ls_ack_cyc;
  int            n_checks, n_errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory answers one cycle after seeing a strobe; douta is junk otherwise.
  task automatic mem_model();
    logic          sf, sa, sw;
    logic [7:0]    a;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      sf = q_mem_ce_fetch; sa = q_mem_ce_alu; sw = q_mem_we;
      a  = q_mem_addr[7:0]; d = q_mem_dina;
      @(posedge clk);
      cyc++;
      ce_dec <= sf && !mem_silent;
      ce_reg <= sa && !mem_silent;
      douta  <= (sf || sa) ? mem[a] : DW'($urandom);
      if (sa && sw && !mem_silent) mem[a] <= d;
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (q_mem_ce_fetch) begin
        last_fetch_strobe_cyc = cyc;
        fetch_strobe_cycs.push_back(cyc);
        check("we_not_with_fetch", q_mem_we, 0);
      end
      if (q_mem_we) check("we_with_alu", q_mem_ce_alu, 1);
      if (q_fetch_ack) begin
        last_fetch_ack_cyc = cyc;
        check("fetch_ack_outstanding", exp_fetch_q.size() > 0, 1);
        if (exp_fetch_q.size() > 0) check("fetch_instr", q_fetch_instr, exp_fetch_q.pop_front());
      end
      if (q_ls_ack) begin
        last_ls_ack_cyc = cyc;
        check("ls_ack_outstanding", exp_ls_q.size() > 0, 1);
        if (exp_ls_q.size() > 0) check("ls_rdata", q_ls_rdata, exp_ls_q.pop_front());
      end
    end
  endtask

  task automatic issue_fetch(input logic [AW-1:0] a);
    exp_fetch_q.push_back(ref_mem[a[7:0]]);
    i_fetch_addr = a;
    i_fetch_req  = 1'b1;
  endtask

  task automatic issue_ls(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_ls_q.push_back(ref_mem[a[7:0]]);
    if (we) ref_mem[a[7:0]] = d;
    i_ls_we    = we;
    i_ls_addr  = a;
    i_ls_wdata = d;
    i_ls_req   = 1'b1;
  endtask

  // Requesters release on their ack; one extra cycle lets ACK return to IDLE.
  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((i_fetch_req || i_ls_req) && n < budget) begin
      tick();
      n++;
      if (q_ls_ack)    i_ls_req    = 1'b0;
      if (q_fetch_ack) i_fetch_req = 1'b0;
    end
    check("acked_within_budget", i_fetch_req || i_ls_req, 0);
    i_fetch_req = 1'b0;
    i_ls_req    = 1'b0;
    tick();
  endtask

  task automatic check_cleared(input string p);
    check({p, "_ce_fetch"}, q_mem_ce_fetch, 0);
    check({p, "_ce_alu"},   q_mem_ce_alu, 0);
    check({p, "_we"},       q_mem_we, 0);
    check({p, "_addr"},     q_mem_addr, 0);
    check({p, "_dina"},     q_mem_dina, 0);
    check({p, "_fetch_ack"}, q_fetch_ack, 0);
    check({p, "_ls_ack"},   q_ls_ack, 0);
    check({p, "_instr"},    q_fetch_instr, 0);
    check({p, "_rdata"},    q_ls_rdata, 0);
    check({p, "_busy"},     q_busy, 0);
    check({p, "_err"},      q_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int            n_ack;
    logic [AW-1:0] a;
    n_checks = 0; n_errors = 0; cyc = 0;
    rst = 1'b1; mem_silent = 1'b0;
    i_fetch_req = 1'b0; i_ls_req = 1'b0; i_ls_we = 1'b0;
    i_fetch_addr = '0; i_ls_addr = '0; i_ls_wdata = '0;
    ce_dec = 1'b0; ce_reg = 1'b0; douta = '0;
    last_fetch_strobe_cyc = 0; last_fetch_ack_cyc = 0; last_ls_ack_cyc = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8'h03] = 16'h1ee0; ref_mem[8'h03] = 16'h1ee0;
    mem[8'h05] = 16'h1234; ref_mem[8'h05] = 16'h1234;
    mem[8'haa] = 16'h00ca; ref_mem[8'haa] = 16'h00ca;
    fork
      mem_model();
      monitor();
    join_none

    repeat (3) tick();
    check_cleared("reset");
    rst = 1'b0;
    tick();

    // fetch only, cycle by cycle
    issue_fetch(16'h0003);
    tick();
    check("f_strobe", q_mem_ce_fetch, 1);
    check("f_no_alu", q_mem_ce_alu, 0);
    check("f_we", q_mem_we, 0);
    check("f_addr", q_mem_addr, 16'h0003);
    check("f_busy", q_busy, 1);
    tick();
    check("f_strobe_drop", q_mem_ce_fetch, 0);
    check("f_no_early_ack", q_fetch_ack, 0);
    tick();
    check("f_ack_n3", q_fetch_ack, 1);
    check("f_instr_n3", q_fetch_instr, 16'h1ee0);
    i_fetch_req = 1'b0;
    tick();
    check("f_ack_one_cycle", q_fetch_ack, 0);
    check("f_instr_hold", q_fetch_instr, 16'h1ee0);

    // simultaneous: load wins, fetch strobed after the ACK cycle
    issue_ls(1'b0, 16'h00aa, 16'h0000);
    issue_fetch(16'h0005);
    wait_done(30);
    check("sim_fetch_after_ack", last_fetch_strobe_cyc - last_ls_ack_cyc, 2);
    check("sim_rdata", q_ls_rdata, 16'h00ca);

    // store then load back
    issue_ls(1'b1, 16'h00ab, 16'hbeef);
    tick();
    check("st_alu", q_mem_ce_alu, 1);
    check("st_we", q_mem_we, 1);
    check("st_dina", q_mem_dina, 16'hbeef);
    check("st_no_fetch", q_mem_ce_fetch, 0);
    tick();
    check("st_we_drop", q_mem_we, 0);
    check("st_alu_drop", q_mem_ce_alu, 0);
    check("st_dina_hold", q_mem_dina, 16'hbeef);
    check("st_addr_hold", q_mem_addr, 16'h00ab);
    wait_done(30);
    issue_ls(1'b0, 16'h00ab, 16'h0000);
    wait_done(30);
    check("ld_back", q_ls_rdata, 16'hbeef);

    // held fetch request: two accesses four cycles apart
    fetch_strobe_cycs.delete();
    issue_fetch(16'h0010);
    exp_fetch_q.push_back(ref_mem[8'h10]);
    n_ack = 0;
    for (int k = 0; k < 20 && n_ack < 2; k++) begin
      tick();
      if (q_fetch_ack) n_ack++;
    end
    i_fetch_req = 1'b0;
    check("held_acks", n_ack, 2);
    repeat (6) tick();
    check("held_strobes", fetch_strobe_cycs.size(), 2);
    if (fetch_strobe_cycs.size() == 2)
      check("held_spacing", fetch_strobe_cycs[1] - fetch_strobe_cycs[0], 4);

    // random mix
    for (int i = 0; i < 10; i++) begin
      a = 16'h0020 + AW'($urandom_range(0, 31));
      case ($urandom_range(0, 2))
        0: issue_fetch(a);
        1: issue_ls(1'($urandom_range(0, 1)), a, DW'($urandom));
        default: begin
          issue_ls(1'b0, a, 16'h0000);
          issue_fetch(a + 16'd1);
        end
      endcase
      wait_done(40);
    end

    // reset in WAIT; late completion must be ignored
    i_ls_we = 1'b0; i_ls_addr = 16'h0040; i_ls_req = 1'b1;
    tick();
    check("rw_strobe", q_mem_ce_alu, 1);
    rst = 1'b1; i_ls_req = 1'b0;
    tick();
    check_cleared("rw_reset");
    rst = 1'b0;
    tick();
    check_cleared("rw_late");
    tick();
    check("rw_no_ack", q_ls_ack, 0);
    check("rw_idle", q_busy, 0);

`ifdef PRCO_MEM_TIMEOUT_EN
    mem_silent = 1'b1;
    exp_fetch_q.push_back(16'h0000);
    i_fetch_addr = 16'h0007; i_fetch_req = 1'b1;
    wait_done(40);
    check("wd_latency", last_fetch_ack_cyc - last_fetch_strobe_cyc, TO);
    check("wd_instr", q_fetch_instr, 16'h0000);
    check("wd_err", q_err, 1);
    mem_silent = 1'b0;
    repeat (3) tick();
    check("wd_err_sticky", q_err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wd_err_reset", q_err, 0);
`else
    check("err_tied", q_err, 0);
`endif

    repeat (4) tick();
    check("fetch_q_drained", exp_fetch_q.size(), 0);
    check("ls_q_drained", exp_ls_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
